dp_instr_sequencer: RTL and testbench

Multi-cycle controller for ARM data-processing instructions (AND..MVN) in the ARM7 core. It accepts one decoded-fetch word, evaluates the condition field against CPSR NZCV, and sequences the single register-file read port for Rn/Rm/Rs. It configures the external barrel shifter and ALU, then issues the Rd write-back and the flag update.

---
 rtl/dp_instr_sequencer.sv | 157 +++++++++++++++
 tb/tb_dp_instr_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_instr_sequencer.sv
// dp_instr_sequencer: multi-cycle sequencer for ARM data-processing instructions (AND..MVN).
// Define DP_SEQ_PERF_COUNT_EN to add the perf_exec/perf_skip retire counters.
module dp_instr_sequencer #(
    parameter int RF_AW = 4,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       cpsr_nzcv,
    output logic             rf_re,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [DW-1:0]    shift_value,
    output logic [1:0]       shift_type,
    output logic [7:0]       shift_amount,
    input  logic [DW-1:0]    shift_result,
    input  logic             shift_carry,
    output logic [3:0]       alu_op,
    output logic [DW-1:0]    alu_a,
    output logic             alu_carry_in,
    input  logic [DW-1:0]    alu_result,
    input  logic [3:0]       alu_nzcv,
    output logic             flags_we,
    output logic [3:0]       flags_wdata,
    output logic             done,
    output logic             executed,
    output logic             pc_written
`ifdef DP_SEQ_PERF_COUNT_EN
    ,
    output logic [31:0]      perf_exec,
    output logic [31:0]      perf_skip
`endif
);
    typedef enum logic [2:0] {IDLE, COND, READ_RN, READ_RM, READ_RS, EXEC} state_t;
    state_t state, state_nx;
    logic [31:0]   ir;
    logic [DW-1:0] op_a, op_b;
    logic [7:0]    rs_amt;
    logic [3:0]    op;
    logic          i_bit, s_bit, is_mov, is_test, is_logic;
    logic          n, z, c, v, cond_base, cond_pass;
    logic [2:0]    csel;
    logic          unused;
    assign unused   = ^{shift_result, ir[27:26]};
    assign op       = ir[24:21];
    assign i_bit    = ir[25];
    assign s_bit    = ir[20];
    assign is_mov   = op[3] & op[2] & op[0];
    assign is_test  = op[3:2] == 2'b10;
    assign is_logic = (~op[2] & ~op[1]) | (op[3] & op[2]);
    assign {n, z, c, v} = cpsr_nzcv;
    assign csel = ir[31:29];
    // Even codes test the base predicate, odd codes its inverse; code 15 (NV) never passes.
    assign cond_base = csel == 3'd0 ? z :
                       csel == 3'd1 ? c :
                       csel == 3'd2 ? n :
                       csel == 3'd3 ? v :
                       csel == 3'd4 ? c & ~z :
                       csel == 3'd5 ? n == v :
                       csel == 3'd6 ? ~z & (n == v) : 1'b1;
    assign cond_pass = csel == 3'd7 ? ~ir[28] : cond_base ^ ir[28];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            rs_amt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && instr_valid) ir <= instr;
            if (state == READ_RN) op_a <= rf_rdata;
            if (state == READ_RM) op_b <= rf_rdata;
            if (state == READ_RS) rs_amt <= rf_rdata[7:0];
        end
    end
    always_comb begin
        state_nx     = state;
        instr_ready  = 1'b0;
        rf_re        = 1'b0;
        rf_raddr     = '0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        shift_value  = '0;
        shift_type   = '0;
        shift_amount = '0;
        alu_op       = '0;
        alu_a        = '0;
        alu_carry_in = 1'b0;
        flags_we     = 1'b0;
        flags_wdata  = '0;
        done         = 1'b0;
        executed     = 1'b0;
        pc_written   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                state_nx    = instr_valid ? COND : IDLE;
            end
            COND: begin
                done     = ~cond_pass;
                state_nx = !cond_pass ? IDLE : !is_mov ? READ_RN : i_bit ? EXEC : READ_RM;
            end
            READ_RN: begin
                rf_re    = 1'b1;
                rf_raddr = RF_AW'(ir[19:16]);
                state_nx = i_bit ? EXEC : READ_RM;
            end
            READ_RM: begin
                rf_re    = 1'b1;
                rf_raddr = RF_AW'(ir[3:0]);
                state_nx = ir[4] ? READ_RS : EXEC;
            end
            READ_RS: begin
                rf_re    = 1'b1;
                rf_raddr = RF_AW'(ir[11:8]);
                state_nx = EXEC;
            end
            EXEC: begin
                shift_value  = i_bit ? DW'(ir[7:0]) : op_b;
                shift_type   = i_bit ? 2'b11 : ir[6:5];
                shift_amount = i_bit ? {3'b0, ir[11:8], 1'b0} : ir[4] ? rs_amt : {3'b0, ir[11:7]};
                alu_op       = op;
                alu_a        = is_mov ? '0 : op_a;
                alu_carry_in = c;
                rf_we        = ~is_test;
                rf_waddr     = RF_AW'(ir[15:12]);
                rf_wdata     = alu_result;
                flags_we     = s_bit;
                flags_wdata  = is_logic ? {alu_nzcv[3:2], shift_carry, v} : alu_nzcv;
                done         = 1'b1;
                executed     = 1'b1;
                pc_written   = ~is_test && ir[15:12] == 4'hF;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
`ifdef DP_SEQ_PERF_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_exec <= '0;
            perf_skip <= '0;
        end else begin
            if (done && executed) perf_exec <= perf_exec + 32'd1;
            if (done && !executed) perf_skip <= perf_skip + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dp_instr_sequencer.sv
// tb_dp_instr_sequencer: directed bench with register file, shifter and ALU models around the sequencer.
module tb_dp_instr_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  cpsr;
    logic        rf_re;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] shift_value;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amount;
    logic [31:0] shift_result;
    logic        shift_carry;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic        alu_carry_in;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzcv;
    logic        flags_we;
    logic [3:0]  flags_wdata;
    logic        done;
    logic        executed;
    logic        pc_written;
`ifdef DP_SEQ_PERF_COUNT_EN
    logic [31:0] perf_exec;
    logic [31:0] perf_skip;
`endif
    logic [31:0] regs [16];
    int          checks = 0;
    int          failures = 0;
    int          lat, stray;
    logic        c_we, c_fwe, c_exec, c_pcw, c_rdy;
    logic [3:0]  c_waddr, c_fw;
    logic [31:0] c_wdata, c_sval, c_alua;
    logic [1:0]  c_stype;
    logic [7:0]  c_samt;
    dp_instr_sequencer dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .cpsr_nzcv(cpsr), .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .shift_value(shift_value), .shift_type(shift_type), .shift_amount(shift_amount),
        .shift_result(shift_result), .shift_carry(shift_carry),
        .alu_op(alu_op), .alu_a(alu_a), .alu_carry_in(alu_carry_in), .alu_result(alu_result),
        .alu_nzcv(alu_nzcv), .flags_we(flags_we), .flags_wdata(flags_wdata),
        .done(done), .executed(executed), .pc_written(pc_written)
`ifdef DP_SEQ_PERF_COUNT_EN
        , .perf_exec(perf_exec), .perf_skip(perf_skip)
`endif
    );
    always #5 clk = ~clk;
    assign rf_rdata = regs[rf_raddr];
    logic [63:0] lsl_w, ror_w;
    always_comb begin
        lsl_w        = {32'b0, shift_value} << shift_amount;
        ror_w        = {shift_value, shift_value} >> shift_amount[4:0];
        shift_result = shift_value;
        shift_carry  = cpsr[1];
        if (shift_amount != 8'd0 && shift_type == 2'd0) begin
            shift_result = lsl_w[31:0];
            shift_carry  = lsl_w[32];
        end else if (shift_amount[4:0] != 5'd0 && shift_type == 2'd3) begin
            shift_result = ror_w[31:0];
            shift_carry  = ror_w[31];
        end
    end
    logic [32:0] sum;
    logic        a_v;
    always_comb begin
        sum = '0;
        a_v = 1'b0;
        case (alu_op)
            4'h0: sum = {1'b0, alu_a & shift_result};
            4'h2, 4'hA: begin
                sum = {1'b0, alu_a} + {1'b0, ~shift_result} + 33'd1;
                a_v = (alu_a[31] != shift_result[31]) && (sum[31] != alu_a[31]);
            end
            4'h4: begin
                sum = {1'b0, alu_a} + {1'b0, shift_result};
                a_v = (alu_a[31] == shift_result[31]) && (sum[31] != alu_a[31]);
            end
            4'hC: sum = {1'b0, alu_a | shift_result};
            4'hD: sum = {1'b0, shift_result};
            4'hF: sum = {1'b0, ~shift_result};
            default: sum = '0;
        endcase
        alu_result = sum[31:0];
        alu_nzcv   = {sum[31], sum[31:0] == 32'd0, sum[32], a_v};
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask
    // Issue one instruction from IDLE, measure cycles to done and capture the retire-cycle outputs.
    task automatic run(input logic [31:0] w, input logic [3:0] flags);
        cpsr = flags;
        instr = w;
        instr_valid = 1'b1;
        c_rdy = instr_ready;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = '0;
        lat = 1;
        stray = 0;
        while (!done && lat < 10) begin
            stray += int'(rf_we | flags_we);
            @(posedge clk); #1;
            lat++;
        end
        c_we = rf_we; c_waddr = rf_waddr; c_wdata = rf_wdata; c_fwe = flags_we; c_fw = flags_wdata;
        c_exec = executed; c_pcw = pc_written; c_sval = shift_value; c_stype = shift_type;
        c_samt = shift_amount; c_alua = alu_a;
        @(posedge clk); #1;
    endtask
    initial begin
        reset = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        cpsr = '0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;
        regs[2] = 5; regs[3] = 7; regs[4] = 9;
        regs[6] = 32'hFFFF_00F0; regs[7] = 32'h1000_0001; regs[8] = 32'h104; regs[14] = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_done", done, 0);
        check("rst_flags_we", flags_we, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", instr_ready, 1);
        check("rst_rf_re", rf_re, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_shift_value", shift_value, 0);
        // ADDS R1,R2,R3
        run(32'hE092_1003, 4'b0000);
        check("adds_ready", c_rdy, 1);
        check("adds_lat", lat, 4);
        check("adds_we", c_we, 1);
        check("adds_waddr", c_waddr, 1);
        check("adds_wdata", c_wdata, 12);
        check("adds_fwe", c_fwe, 1);
        check("adds_flags", c_fw, 4'b0000);
        check("adds_exec", c_exec, 1);
        check("adds_pcw", c_pcw, 0);
        check("idle_ready", instr_ready, 1);
        // MOVEQ R0,#0xFF ROR 8, Z set
        run(32'h03A0_04FF, 4'b0100);
        check("moveq_lat", lat, 2);
        check("moveq_stype", c_stype, 2'b11);
        check("moveq_samt", c_samt, 8);
        check("moveq_sval", c_sval, 32'hFF);
        check("moveq_alua", c_alua, 0);
        check("moveq_wdata", c_wdata, 32'hFF00_0000);
        check("moveq_we", c_we, 1);
        check("moveq_fwe", c_fwe, 0);
        // MOVEQ with Z clear: skipped
        run(32'h03A0_04FF, 4'b0000);
        check("moveq_skip_lat", lat, 1);
        check("moveq_skip_exec", c_exec, 0);
        check("moveq_skip_we", c_we, 0);
        check("moveq_skip_fwe", c_fwe, 0);
        // CMP R4,R4
        run(32'hE154_0004, 4'b0000);
        check("cmp_lat", lat, 4);
        check("cmp_we", c_we, 0);
        check("cmp_fwe", c_fwe, 1);
        check("cmp_flags", c_fw, 4'b0110);
        check("cmp_stray", stray, 0);
        // ANDS R5,R6,R7,LSL R8 with V set, C clear
        run(32'hE016_5817, 4'b0001);
        check("ands_lat", lat, 5);
        check("ands_samt", c_samt, 4);
        check("ands_stype", c_stype, 0);
        check("ands_waddr", c_waddr, 5);
        check("ands_wdata", c_wdata, 32'h10);
        check("ands_flags", c_fw, 4'b0011);
        // MOV PC,R14
        run(32'hE1A0_F00E, 4'b0000);
        check("movpc_lat", lat, 3);
        check("movpc_waddr", c_waddr, 15);
        check("movpc_wdata", c_wdata, 32'h100);
        check("movpc_pcw", c_pcw, 1);
        // Condition 0xF never executes
        run(32'hF1A0_F00E, 4'b1111);
        check("nv_lat", lat, 1);
        check("nv_exec", c_exec, 0);
        check("nv_pcw", c_pcw, 0);
        check("nv_we", c_we, 0);
`ifdef DP_SEQ_PERF_COUNT_EN
        check("perf_exec", perf_exec, 5);
        check("perf_skip", perf_skip, 2);
`endif
        // Reset while in READ_RM of ADDS
        cpsr = 4'b0000;
        instr = 32'hE092_1003;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rm_re", rf_re, 1);
        check("rm_raddr", rf_raddr, 3);
        reset = 1'b1;
        #1;
        check("rm_rst_re", rf_re, 0);
        check("rm_rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            stray += int'(rf_we | flags_we | done);
            @(posedge clk); #1;
        end
        check("rm_rst_stray", stray, 0);
        check("rm_rst_ready", instr_ready, 1);
`ifdef DP_SEQ_PERF_COUNT_EN
        check("rm_rst_perf_exec", perf_exec, 0);
        check("rm_rst_perf_skip", perf_skip, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
